// File: rtl/load_seq.sv
// load_seq: FIFO-buffered reload sequencer issuing immediate or wrap-aligned counter loads
module load_seq #(
    parameter int W = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [W-1:0]             req_val_i,
    input  logic                     req_imm_i,
    input  logic                     flush_i,
    input  logic [W-1:0]             count_i,
    output logic                     load_o,
    output logic [W-1:0]             load_val_o,
    output logic [$clog2(DEPTH):0]   fifo_cnt_o,
    output logic                     busy_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];
    localparam logic [W-1:0] MAX = '1;
    localparam logic [W-1:0] MAX_M1 = {{(W-1){1'b1}}, 1'b0};
    typedef enum logic [1:0] {IDLE, ARM, FIRE} state_t;
    state_t state, state_nx;
    logic [W:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] cnt;
    logic hold_imm, push, pop, trig;
    logic [W-1:0] hold_val, prev_count;
    assign req_ready_o = cnt != FULL && !flush_i && !reset;
    assign push = req_valid_i && req_ready_o;
    assign pop = state == IDLE && cnt != '0 && !flush_i;
    assign trig = hold_imm || count_i == MAX_M1 || (count_i == MAX && prev_count == MAX);
    assign fifo_cnt_o = cnt;
    assign busy_o = state != IDLE;
    assign load_o = state == FIRE;
    always_comb begin
        state_nx = state == IDLE ? (pop ? ARM : IDLE)
                 : state == ARM  ? (flush_i ? IDLE : trig ? FIRE : ARM)
                 : IDLE;
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {req_imm_i, req_val_i};
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            hold_imm   <= 1'b0;
            hold_val   <= '0;
            prev_count <= '0;
            load_val_o <= '0;
        end else begin
            state      <= state_nx;
            prev_count <= count_i;
            if (flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            end
            if (pop) {hold_imm, hold_val} <= mem[rd_ptr];
            if (state == ARM && state_nx == FIRE) load_val_o <= hold_val;
        end
    end
endmodule

// File: tb/tb_load_seq.sv
// tb_load_seq: randomized and directed checks of load_seq against a queue-based reference model
module tb_load_seq;
    localparam int W = 4;
    localparam int DEPTH = 4;
    logic clk = 0, reset = 1, req_valid = 0, req_imm = 0, flush = 0;
    logic [W-1:0] req_val = '0, count = '0;
    logic req_ready, load, busy;
    logic [W-1:0] load_val;
    logic [$clog2(DEPTH):0] fifo_cnt;
    int n_chk = 0, n_fail = 0;
    logic [W:0] q[$];
    logic [W-1:0] seen[$];
    int m_st, h_val, m_prev, m_lv, rld, gap;
    bit h_imm, saw_full, chk_align;

    always #5 clk = ~clk;

    load_seq #(.W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_val_i(req_val), .req_imm_i(req_imm), .flush_i(flush), .count_i(count),
        .load_o(load), .load_val_o(load_val), .fifo_cnt_o(fifo_cnt), .busy_o(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_st = 0; h_imm = 0; h_val = 0; m_prev = 0; m_lv = 0; gap = 99;
    endtask

    // Model phases: 0 waiting for work, 1 holding an armed request, 2 pulsing the load
    task automatic cycle_step();
        bit rdy, psh, trg, ld;
        int nst;
        logic [W:0] e;
        rdy = q.size() < DEPTH && !flush;
        psh = req_valid && rdy;
        trg = h_imm || count == 14 || (count == 15 && m_prev == 15);
        ld = m_st == 2;
        if (ld && !h_imm && chk_align) chk("aligned_at_max", count, 15);
        nst = m_st;
        if (m_st == 0 && !flush && q.size() > 0) begin
            e = q.pop_front();
            h_imm = e[W];
            h_val = int'(e[W-1:0]);
            nst = 1;
        end else if (m_st == 1) nst = flush ? 0 : trg ? 2 : 1;
        else if (m_st == 2) nst = 0;
        if (m_st == 1 && nst == 2) m_lv = h_val;
        if (flush) q.delete();
        if (psh) q.push_back({req_imm, req_val});
        m_prev = int'(count);
        m_st = nst;
        @(posedge clk);
        #1;
        count = ld ? W'(m_lv) : count == 15 ? W'(rld) : count + 1'b1;
        gap++;
        chk("load", load, m_st == 2);
        chk("load_val", load_val, m_lv);
        chk("fifo_cnt", fifo_cnt, q.size());
        chk("busy", busy, m_st != 0);
        chk("ready", req_ready, q.size() < DEPTH && !flush);
        if (q.size() == DEPTH) saw_full = 1;
        if (load) begin
            chk("load_gap_ge3", gap >= 3, 1);
            gap = 0;
            seen.push_back(load_val);
        end
    endtask

    initial begin
        int k, sent;
        model_reset();
        rld = 0;
        chk_align = 1;
        #3;
        chk("rst_ready", req_ready, 0);
        chk("rst_load", load, 0);
        chk("rst_fifo", fifo_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_load_val", load_val, 0);
        #19 reset = 0;
        #1 chk("ready_after_reset", req_ready, 1);
        repeat (20) cycle_step();

        req_valid = 1; req_imm = 1; req_val = 5;
        cycle_step();
        req_valid = 0;
        chk("imm_e0_cnt", fifo_cnt, 1);
        cycle_step();
        chk("imm_e1_cnt", fifo_cnt, 0);
        chk("imm_e1_load", load, 0);
        cycle_step();
        chk("imm_e2_load", load, 1);
        chk("imm_e2_val", load_val, 5);
        cycle_step();
        chk("imm_e3_load", load, 0);
        chk("imm_e3_val", load_val, 5);

        req_valid = 1; req_imm = 0; req_val = 3;
        cycle_step();
        req_valid = 0;
        k = 0;
        while (!load && k < 40) begin cycle_step(); k++; end
        chk("wrap_fired", load, 1);
        chk("wrap_count_max", count, 15);
        cycle_step();
        chk("wrap_reloaded", count, 3);
        cycle_step();
        chk("wrap_next", count, 4);

        saw_full = 0;
        seen.delete();
        sent = 0;
        k = 0;
        while (sent < 7 && k < 80) begin
            req_valid = 1; req_imm = 1; req_val = W'(sent + 8);
            if (q.size() < DEPTH) sent++;
            cycle_step();
            k++;
        end
        req_valid = 0;
        repeat (25) cycle_step();
        chk("b2b_full_seen", saw_full, 1);
        chk("b2b_num_loads", seen.size(), 7);
        for (int i = 0; i < seen.size(); i++) chk("b2b_order", seen[i], i + 8);

        rld = 15;
        repeat (20) cycle_step();
        chk("stuck_at_max", count, 15);
        req_valid = 1; req_imm = 0; req_val = 7;
        cycle_step();
        req_valid = 0;
        k = 0;
        while (!load && k < 10) begin cycle_step(); k++; end
        chk("stuck_fired", load, 1);
        chk("stuck_val", load_val, 7);
        cycle_step();
        chk("stuck_loaded", count, 7);
        rld = 0;

        k = 0;
        while (count != 0 && k < 20) begin cycle_step(); k++; end
        for (int i = 1; i <= 3; i++) begin
            req_valid = 1; req_imm = 0; req_val = W'(i);
            cycle_step();
        end
        chk("pre_flush_busy", busy, 1);
        seen.delete();
        flush = 1; req_val = 9;
        #1 chk("flush_ready_low", req_ready, 0);
        cycle_step();
        flush = 0; req_valid = 0;
        chk("flush_fifo", fifo_cnt, 0);
        chk("flush_busy", busy, 0);
        chk("flush_load", load, 0);
        repeat (20) cycle_step();
        chk("flush_no_loads", seen.size(), 0);

        chk_align = 0;
        repeat (400) begin
            req_valid = 1'($urandom_range(0, 1));
            req_imm = 1'($urandom_range(0, 1));
            req_val = W'($urandom_range(0, 15));
            flush = $urandom_range(0, 19) == 0;
            if ($urandom_range(0, 49) == 0) rld = $urandom_range(0, 15);
            cycle_step();
        end
        req_valid = 0; rld = 0;
        flush = 1;
        cycle_step();
        flush = 0;
        repeat (5) cycle_step();
        chk_align = 1;

        req_valid = 1; req_imm = 1; req_val = 6;
        cycle_step();
        req_valid = 0;
        k = 0;
        while (m_st != 2 && k < 10) begin cycle_step(); k++; end
        chk("mid_fire_load", load, 1);
        #2 reset = 1;
        #1;
        chk("async_rst_load", load, 0);
        chk("async_rst_ready", req_ready, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_fifo", fifo_cnt, 0);
        chk("async_rst_val", load_val, 0);
        model_reset();
        @(negedge clk) reset = 0;
        repeat (10) cycle_step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
